// File: rtl/rob_multi_wb_if.sv
// Reorder buffer port bundle: issue/lookup, writeback, commit and flush.
// master drives issue and writeback; slave is the ROB itself.
interface rob_multi_wb_if #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int NUM_WB = 2
);
  logic                     rdy;
  logic                     iss_valid;
  logic [1:0]               iss_type;
  logic [REG_W-1:0]         iss_dest;
  logic [ADDR_W-1:0]        iss_pc;
  logic                     iss_pred_taken;
  logic [IDX_W-1:0]         iss_rs1_tag;
  logic [IDX_W-1:0]         iss_rs2_tag;
  logic                     alloc_ok;
  logic [IDX_W-1:0]         alloc_tag;
  logic                     rs1_ready;
  logic [DATA_W-1:0]        rs1_data;
  logic                     rs2_ready;
  logic [DATA_W-1:0]        rs2_data;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*IDX_W-1:0]  wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB-1:0]        wb_taken;
  logic [NUM_WB*ADDR_W-1:0] wb_target;
  logic                     cm_valid;
  logic [REG_W-1:0]         cm_dest;
  logic [DATA_W-1:0]        cm_data;
  logic [IDX_W-1:0]         cm_tag;
  logic                     st_commit;
  logic                     flush;
  logic [ADDR_W-1:0]        flush_pc;
  logic [IDX_W:0]           count;

  modport master (
    output rdy, iss_valid, iss_type, iss_dest, iss_pc, iss_pred_taken, iss_rs1_tag, iss_rs2_tag,
           wb_valid, wb_tag, wb_data, wb_taken, wb_target,
    input  alloc_ok, alloc_tag, rs1_ready, rs1_data, rs2_ready, rs2_data,
           cm_valid, cm_dest, cm_data, cm_tag, st_commit, flush, flush_pc, count
  );

  modport slave (
    input  rdy, iss_valid, iss_type, iss_dest, iss_pc, iss_pred_taken, iss_rs1_tag, iss_rs2_tag,
           wb_valid, wb_tag, wb_data, wb_taken, wb_target,
    output alloc_ok, alloc_tag, rs1_ready, rs1_data, rs2_ready, rs2_data,
           cm_valid, cm_dest, cm_data, cm_tag, st_commit, flush, flush_pc, count
  );
endinterface

// File: rtl/rob_multi_wb.sv
// In-order-commit reorder buffer with NUM_WB writeback ports; commit/flush outputs registered one cycle
// after the decision. Issue is refused when full or while flush is high; rdy=0 freezes everything.
module rob_multi_wb #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int NUM_WB = 2
) (
  input logic          clk,
  input logic          rst,
  rob_multi_wb_if.slave bus
);
  localparam logic [1:0] T_OTHER  = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [1:0] T_JALR   = 2'd3;

  logic [1:0]        e_type   [DEPTH];
  logic [REG_W-1:0]  e_dest   [DEPTH];
  logic [ADDR_W-1:0] e_pc     [DEPTH];
  logic              e_pred   [DEPTH];
  logic [DATA_W-1:0] e_data   [DEPTH];
  logic              e_taken  [DEPTH];
  logic [ADDR_W-1:0] e_target [DEPTH];
  logic [DEPTH-1:0]  e_ready;

  logic [IDX_W-1:0]  head, tail;
  logic [IDX_W:0]    count;
  logic              cm_valid, st_commit, flush;
  logic [REG_W-1:0]  cm_dest;
  logic [DATA_W-1:0] cm_data;
  logic [IDX_W-1:0]  cm_tag;
  logic [ADDR_W-1:0] flush_pc;

  logic              alloc_ok, issue_ok, do_commit, flush_now;
  logic [ADDR_W-1:0] flush_target;
  logic              rs1_ready, rs2_ready;
  logic [DATA_W-1:0] rs1_data, rs2_data;

  // A tag is live when its distance from head is below the occupancy.
  function automatic logic occupied(input logic [IDX_W-1:0] t);
    logic [IDX_W-1:0] off;
    off = t - head;
    return {1'b0, off} < count;
  endfunction

  assign alloc_ok  = (count != (IDX_W+1)'(DEPTH)) && !flush;
  assign issue_ok  = bus.iss_valid && alloc_ok;
  assign do_commit = (count != '0) && e_ready[head];

  always_comb begin
    flush_now    = 1'b0;
    flush_target = e_target[head];
    if (do_commit) begin
      if (e_type[head] == T_JALR) begin
        flush_now = 1'b1;
      end else if (e_type[head] == T_BRANCH && e_taken[head] != e_pred[head]) begin
        flush_now    = 1'b1;
        flush_target = e_taken[head] ? e_target[head] : e_pc[head] + ADDR_W'(4);
      end
    end
  end

  // Operand lookup; ports scanned high to low so port 0 has the final say.
  always_comb begin
    rs1_ready = e_ready[bus.iss_rs1_tag];
    rs1_data  = e_data[bus.iss_rs1_tag];
    rs2_ready = e_ready[bus.iss_rs2_tag];
    rs2_data  = e_data[bus.iss_rs2_tag];
    for (int p = NUM_WB-1; p >= 0; p--) begin
      if (bus.wb_valid[p] && bus.wb_tag[p*IDX_W +: IDX_W] == bus.iss_rs1_tag) begin
        rs1_ready = 1'b1;
        rs1_data  = bus.wb_data[p*DATA_W +: DATA_W];
      end
      if (bus.wb_valid[p] && bus.wb_tag[p*IDX_W +: IDX_W] == bus.iss_rs2_tag) begin
        rs2_ready = 1'b1;
        rs2_data  = bus.wb_data[p*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      e_ready   <= '0;
      cm_valid  <= 1'b0;
      st_commit <= 1'b0;
      flush     <= 1'b0;
      cm_dest   <= '0;
      cm_data   <= '0;
      cm_tag    <= '0;
      flush_pc  <= '0;
    end else if (bus.rdy) begin
      cm_valid  <= 1'b0;
      st_commit <= 1'b0;
      flush     <= 1'b0;
      if (issue_ok) begin
        e_type[tail]  <= bus.iss_type;
        e_dest[tail]  <= bus.iss_dest;
        e_pc[tail]    <= bus.iss_pc;
        e_pred[tail]  <= bus.iss_pred_taken;
        e_ready[tail] <= 1'b0;
      end
      for (int p = NUM_WB-1; p >= 0; p--) begin
        if (bus.wb_valid[p] && occupied(bus.wb_tag[p*IDX_W +: IDX_W])) begin
          e_ready[bus.wb_tag[p*IDX_W +: IDX_W]]  <= 1'b1;
          e_data[bus.wb_tag[p*IDX_W +: IDX_W]]   <= bus.wb_data[p*DATA_W +: DATA_W];
          e_taken[bus.wb_tag[p*IDX_W +: IDX_W]]  <= bus.wb_taken[p];
          e_target[bus.wb_tag[p*IDX_W +: IDX_W]] <= bus.wb_target[p*ADDR_W +: ADDR_W];
        end
      end
      if (do_commit) begin
        cm_dest   <= e_dest[head];
        cm_data   <= e_data[head];
        cm_tag    <= head;
        cm_valid  <= (e_type[head] == T_OTHER) || (e_type[head] == T_JALR);
        st_commit <= (e_type[head] == T_STORE);
        if (flush_now) begin
          flush    <= 1'b1;
          flush_pc <= flush_target;
        end
      end
      // Mispredict discards everything younger, including this cycle's issue and writebacks.
      if (flush_now) begin
        head    <= head + IDX_W'(1);
        tail    <= head + IDX_W'(1);
        count   <= '0;
        e_ready <= '0;
      end else begin
        head  <= head + IDX_W'(do_commit);
        tail  <= tail + IDX_W'(issue_ok);
        count <= count + (IDX_W+1)'(issue_ok) - (IDX_W+1)'(do_commit);
      end
    end
  end

  assign bus.alloc_ok  = alloc_ok;
  assign bus.alloc_tag = tail;
  assign bus.rs1_ready = rs1_ready;
  assign bus.rs1_data  = rs1_data;
  assign bus.rs2_ready = rs2_ready;
  assign bus.rs2_data  = rs2_data;
  assign bus.cm_valid  = cm_valid;
  assign bus.cm_dest   = cm_dest;
  assign bus.cm_data   = cm_data;
  assign bus.cm_tag    = cm_tag;
  assign bus.st_commit = st_commit;
  assign bus.flush     = flush;
  assign bus.flush_pc  = flush_pc;
  assign bus.count     = count;
endmodule

// File: tb/tb_rob_multi_wb.sv
// Scenario bench for rob_multi_wb: commits are checked against a queue filled at issue time,
// with result data taken from a per-tag model written when writebacks are driven.
module tb_rob_multi_wb;
  localparam int DEPTH = 16, IDX_W = 4, DATA_W = 32, ADDR_W = 32, REG_W = 5, NUM_WB = 2;

  typedef struct packed {
    logic [IDX_W-1:0] tag;
    logic [REG_W-1:0] dest;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [DATA_W-1:0] model_data [DEPTH];

  rob_multi_wb_if bus ();
  rob_multi_wb dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0;
    bus.wb_valid  = '0;
  endtask

  task automatic do_reset();
    idle();
    bus.rdy = 1'b1;
    bus.iss_type = 2'd0; bus.iss_dest = '0; bus.iss_pc = '0; bus.iss_pred_taken = 1'b0;
    bus.iss_rs1_tag = '0; bus.iss_rs2_tag = '0;
    bus.wb_tag = '0; bus.wb_data = '0; bus.wb_taken = '0; bus.wb_target = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drive_issue(input logic [1:0] t, input logic [REG_W-1:0] d, input logic [ADDR_W-1:0] pc,
                             input logic pred, input logic [IDX_W-1:0] tag, input logic push);
    bus.iss_valid = 1'b1; bus.iss_type = t; bus.iss_dest = d; bus.iss_pc = pc; bus.iss_pred_taken = pred;
    if (push) sb.push_back('{tag: tag, dest: d});
  endtask

  task automatic wb_set(input int p, input logic [IDX_W-1:0] tag, input logic [DATA_W-1:0] data,
                        input logic taken, input logic [ADDR_W-1:0] target);
    bus.wb_valid[p] = 1'b1;
    bus.wb_tag[p*IDX_W +: IDX_W] = tag;
    bus.wb_data[p*DATA_W +: DATA_W] = data;
    bus.wb_taken[p] = taken;
    bus.wb_target[p*ADDR_W +: ADDR_W] = target;
    model_data[tag] = data;
  endtask

  task automatic test_reset();
    do_reset();
    bus.iss_rs1_tag = 4'd3; #1;
    vectors++; if (bus.count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.count); end
    vectors++; if (bus.cm_valid !== 1'b0 || bus.st_commit !== 1'b0 || bus.flush !== 1'b0) begin
      miscompares++; $display("FAIL reset_pulses got cm=%b st=%b fl=%b want 0 0 0", bus.cm_valid, bus.st_commit, bus.flush); end
    vectors++; if (bus.flush_pc !== 32'd0 || bus.cm_data !== 32'd0) begin
      miscompares++; $display("FAIL reset_regs got flush_pc=%h cm_data=%h want 0 0", bus.flush_pc, bus.cm_data); end
    vectors++; if (bus.alloc_ok !== 1'b1 || bus.alloc_tag !== 4'd0) begin
      miscompares++; $display("FAIL reset_alloc got ok=%b tag=%0d want 1 0", bus.alloc_ok, bus.alloc_tag); end
    vectors++; if (bus.rs1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", bus.rs1_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        bus.rdy = 1'b0;
        drive_issue(2'd0, 5'd1, 32'h0, 1'b0, 4'd0, 1'b0);
        step();
        bus.rdy = 1'b1;
        vectors++; if (bus.count !== 5'd8) begin miscompares++; $display("FAIL fill_rdy_hold got %0d want 8", bus.count); end
      end
      drive_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 4'(i), 1'b0);
      step();
    end
    vectors++; if (bus.count !== 5'd16 || bus.alloc_ok !== 1'b0) begin
      miscompares++; $display("FAIL fill_full got count=%0d ok=%b want 16 0", bus.count, bus.alloc_ok); end
    vectors++; if (bus.alloc_tag !== 4'd0) begin miscompares++; $display("FAIL fill_tail_wrap got %0d want 0", bus.alloc_tag); end
    step();
    idle();
    vectors++; if (bus.count !== 5'd16) begin miscompares++; $display("FAIL fill_17th got %0d want 16", bus.count); end
  endtask

  task automatic test_ooo();
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 4'(i), 1'b1);
      step();
    end
    idle();
    wb_set(0, 4'd2, 32'h33, 1'b0, 32'h0); step(); idle();
    wb_set(0, 4'd0, 32'h22, 1'b0, 32'h0); step(); idle();
    wb_set(0, 4'd1, 32'h11, 1'b0, 32'h0); step(); idle();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus.cm_valid !== 1'b1) begin
        miscompares++; $display("FAIL ooo_consecutive got cm_valid=%b want 1 at slot %0d", bus.cm_valid, k);
      end else if (sb.size() == 0) begin
        miscompares++; $display("FAIL ooo_extra got tag=%0d want no commit", bus.cm_tag);
      end else begin
        e = sb.pop_front();
        if (bus.cm_tag !== e.tag || bus.cm_dest !== e.dest || bus.cm_data !== model_data[e.tag]) begin
          miscompares++;
          $display("FAIL ooo_commit got tag=%0d dest=%0d data=%h want tag=%0d dest=%0d data=%h",
                   bus.cm_tag, bus.cm_dest, bus.cm_data, e.tag, e.dest, model_data[e.tag]);
        end
      end
      step();
    end
    vectors++; if (bus.count !== 5'd0 || sb.size() != 0) begin
      miscompares++; $display("FAIL ooo_drained got count=%0d pending=%0d want 0 0", bus.count, sb.size()); end
  endtask

  task automatic test_dual_port();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 4'(i), 1'b0);
      step();
    end
    idle();
    wb_set(1, 4'd5, 32'hBB, 1'b0, 32'h0);
    wb_set(0, 4'd5, 32'hAA, 1'b0, 32'h0);
    bus.iss_rs1_tag = 4'd5; bus.iss_rs2_tag = 4'd4; #1;
    vectors++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'hAA) begin
      miscompares++; $display("FAIL dual_bypass got ready=%b data=%h want 1 000000aa", bus.rs1_ready, bus.rs1_data); end
    vectors++; if (bus.rs2_ready !== 1'b0) begin miscompares++; $display("FAIL dual_other_tag got %b want 0", bus.rs2_ready); end
    step(); idle(); #1;
    vectors++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'hAA) begin
      miscompares++; $display("FAIL dual_stored got ready=%b data=%h want 1 000000aa", bus.rs1_ready, bus.rs1_data); end
    wb_set(0, 4'd9, 32'h99, 1'b0, 32'h0);
    bus.iss_rs2_tag = 4'd9;
    step(); idle(); #1;
    vectors++; if (bus.rs2_ready !== 1'b0) begin
      miscompares++; $display("FAIL dual_unoccupied_wb got ready=%b want 0", bus.rs2_ready); end
  endtask

  task automatic test_mispredict();
    do_reset();
    drive_issue(2'd2, 5'd0, 32'h100, 1'b0, 4'd0, 1'b0); step();
    for (int i = 1; i < 4; i++) begin
      drive_issue(2'd0, 5'(i), 32'h100 + 32'(i * 4), 1'b0, 4'(i), 1'b0);
      step();
    end
    idle();
    wb_set(1, 4'd0, 32'h0, 1'b1, 32'h200); step(); idle();
    drive_issue(2'd0, 5'd9, 32'h500, 1'b0, 4'd4, 1'b0);
    wb_set(0, 4'd1, 32'h77, 1'b0, 32'h0);
    step();
    bus.wb_valid = '0;
    vectors++; if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h200) begin
      miscompares++; $display("FAIL mispredict_flush got flush=%b pc=%h want 1 00000200", bus.flush, bus.flush_pc); end
    vectors++; if (bus.count !== 5'd0 || bus.alloc_ok !== 1'b0 || bus.cm_valid !== 1'b0) begin
      miscompares++; $display("FAIL mispredict_state got count=%0d ok=%b cm=%b want 0 0 0", bus.count, bus.alloc_ok, bus.cm_valid); end
    step(); idle();
    vectors++; if (bus.flush !== 1'b0 || bus.count !== 5'd0 || bus.alloc_tag !== 4'd1) begin
      miscompares++; $display("FAIL mispredict_after got flush=%b count=%0d tail=%0d want 0 0 1", bus.flush, bus.count, bus.alloc_tag); end
  endtask

  task automatic test_correct_predict();
    exp_t e;
    do_reset();
    drive_issue(2'd2, 5'd0, 32'h40, 1'b1, 4'd0, 1'b0); step();
    drive_issue(2'd0, 5'd7, 32'h44, 1'b0, 4'd1, 1'b1); step();
    idle();
    wb_set(0, 4'd0, 32'h0, 1'b1, 32'h80);
    wb_set(1, 4'd1, 32'h55, 1'b0, 32'h0);
    step(); idle();
    step();
    vectors++; if (bus.flush !== 1'b0 || bus.cm_valid !== 1'b0 || bus.count !== 5'd1) begin
      miscompares++; $display("FAIL correct_branch got flush=%b cm=%b count=%0d want 0 0 1", bus.flush, bus.cm_valid, bus.count); end
    step();
    vectors++;
    if (bus.cm_valid !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL correct_younger got cm_valid=%b pending=%0d want 1 1", bus.cm_valid, sb.size());
    end else begin
      e = sb.pop_front();
      if (bus.cm_tag !== e.tag || bus.cm_dest !== e.dest || bus.cm_data !== model_data[e.tag]) begin
        miscompares++;
        $display("FAIL correct_younger got tag=%0d dest=%0d data=%h want tag=%0d dest=%0d data=%h",
                 bus.cm_tag, bus.cm_dest, bus.cm_data, e.tag, e.dest, model_data[e.tag]);
      end
    end
  endtask

  task automatic test_wrap_jalr();
    exp_t e;
    bit   seen;
    do_reset();
    for (int i = 0; i < 16 + 10; i++) begin
      idle();
      if (i < 15) drive_issue(2'd0, 5'(i + 1), 32'(i * 4), 1'b0, 4'(i), 1'b1);
      if (i > 0 && i < 16) wb_set(0, 4'(i - 1), 32'h1000 + 32'(i - 1), 1'b0, 32'h0);
      step();
      if (i == 10) begin
        vectors++; if (bus.count !== 5'd2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", bus.count); end
      end
      if (bus.cm_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra got tag=%0d want no commit", bus.cm_tag);
        end else begin
          e = sb.pop_front();
          if (bus.cm_tag !== e.tag || bus.cm_dest !== e.dest || bus.cm_data !== model_data[e.tag]) begin
            miscompares++;
            $display("FAIL b2b_commit got tag=%0d dest=%0d data=%h want tag=%0d dest=%0d data=%h",
                     bus.cm_tag, bus.cm_dest, bus.cm_data, e.tag, e.dest, model_data[e.tag]);
          end
        end
      end
    end
    idle();
    vectors++; if (sb.size() != 0 || bus.count !== 5'd0 || bus.alloc_tag !== 4'd15) begin
      miscompares++; $display("FAIL b2b_drain got pending=%0d count=%0d tail=%0d want 0 0 15", sb.size(), bus.count, bus.alloc_tag); end
    drive_issue(2'd3, 5'd9, 32'h300, 1'b0, 4'd15, 1'b1); step(); idle();
    wb_set(1, 4'd15, 32'h304, 1'b1, 32'h80); step(); idle();
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      if (bus.cm_valid === 1'b1) seen = 1'b1;
      else step();
    end
    vectors++;
    if (!seen || sb.size() == 0) begin
      miscompares++; $display("FAIL jalr_commit got cm_valid=%b (timeout) want 1", bus.cm_valid);
    end else begin
      e = sb.pop_front();
      if (bus.cm_tag !== e.tag || bus.cm_dest !== e.dest || bus.cm_data !== model_data[e.tag]) begin
        miscompares++;
        $display("FAIL jalr_commit got tag=%0d dest=%0d data=%h want tag=%0d dest=%0d data=%h",
                 bus.cm_tag, bus.cm_dest, bus.cm_data, e.tag, e.dest, model_data[e.tag]);
      end
    end
    vectors++; if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h80) begin
      miscompares++; $display("FAIL jalr_flush got flush=%b pc=%h want 1 00000080", bus.flush, bus.flush_pc); end
    vectors++; if (bus.alloc_tag !== 4'd0 || bus.count !== 5'd0) begin
      miscompares++; $display("FAIL jalr_wrap got tail=%0d count=%0d want 0 0", bus.alloc_tag, bus.count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo();
    test_dual_port();
    test_mispredict();
    test_correct_predict();
    test_wrap_jalr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
